// File: rtl/matmac_sequencer.sv
// Matrix multiply-accumulate sequencer: C = A x B over a shared data-memory
// port, one element access per granted request.
module matmac_sequencer #(
    parameter int MAX_N = 8,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    dim,
    input  logic [AW-1:0] base_a,
    input  logic [AW-1:0] base_b,
    input  logic [AW-1:0] base_c,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_gnt,
    input  logic [31:0]   mem_rdata
);

    localparam int IW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int XW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_MAC,
        S_WR_C,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    dim_q, dim_d;
    logic [AW-1:0] base_a_q, base_a_d;
    logic [AW-1:0] base_b_q, base_b_d;
    logic [AW-1:0] base_c_q, base_c_d;
    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] j_q, j_d;
    logic [IW-1:0] k_q, k_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   op_a_q, op_a_d;
    logic [31:0]   op_b_q, op_b_d;
    logic          err_q, err_d;

    logic [3:0]    last_idx;
    logic          i_last, j_last, k_last;
    logic          dim_zero, dim_bad;
    logic [XW-1:0] a_idx, b_idx, c_idx;
    logic [31:0]   prod;

    assign last_idx = dim_q - 4'd1;
    assign i_last   = (4'(i_q) == last_idx);
    assign j_last   = (4'(j_q) == last_idx);
    assign k_last   = (4'(k_q) == last_idx);
    assign dim_zero = (dim == 4'd0);
    assign dim_bad  = ({28'd0, dim} > 32'(MAX_N));

    // Row-major element indices; products stay far below 2^XW.
    assign a_idx = XW'(i_q) * XW'(dim_q) + XW'(k_q);
    assign b_idx = XW'(k_q) * XW'(dim_q) + XW'(j_q);
    assign c_idx = XW'(i_q) * XW'(dim_q) + XW'(j_q);
    assign prod  = op_a_q * op_b_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dim_zero || dim_bad) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD_A;
                    end
                end
            end
            S_RD_A: begin
                if (mem_gnt) begin
                    state_d = S_RD_B;
                end
            end
            S_RD_B: begin
                if (mem_gnt) begin
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                state_d = k_last ? S_WR_C : S_RD_A;
            end
            S_WR_C: begin
                if (mem_gnt) begin
                    state_d = (i_last && j_last) ? S_DONE : S_RD_A;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            S_RD_A: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = base_a_q + AW'({a_idx, 2'b00});
            end
            S_RD_B: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = base_b_q + AW'({b_idx, 2'b00});
            end
            S_MAC: begin
                busy = 1'b1;
            end
            S_WR_C: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = base_c_q + AW'({c_idx, 2'b00});
                mem_wdata = acc_q;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign err = err_q;

    always_comb begin
        dim_d    = dim_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        base_c_d = base_c_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        acc_d    = acc_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dim_d    = dim;
                    base_a_d = base_a;
                    base_b_d = base_b;
                    base_c_d = base_c;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    acc_d    = '0;
                    err_d    = dim_bad;
                end
            end
            S_RD_A: begin
                if (mem_gnt) begin
                    op_a_d = mem_rdata;
                end
            end
            S_RD_B: begin
                if (mem_gnt) begin
                    op_b_d = mem_rdata;
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod;
                if (!k_last) begin
                    k_d = k_q + IW'(1);
                end
            end
            S_WR_C: begin
                if (mem_gnt) begin
                    k_d   = '0;
                    acc_d = '0;
                    if (j_last) begin
                        j_d = '0;
                        i_d = i_q + IW'(1);
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dim_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_c_q <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            dim_q    <= dim_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            base_c_q <= base_c_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_matmac_sequencer.sv
// Scoreboard bench for matmac_sequencer: memory responder with grant
// policies, reference matrix product, and latency/handshake checks.
module tb_matmac_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  dim = 4'd0;
    logic [31:0] base_a = '0;
    logic [31:0] base_b = '0;
    logic [31:0] base_c = '0;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0;
    logic [31:0] mem_rdata;

    matmac_sequencer #(.MAX_N(8), .AW(32)) dut (
        .clk(clk), .rst(rst), .start(start), .dim(dim),
        .base_a(base_a), .base_b(base_b), .base_c(base_c),
        .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];
    assign mem_rdata = mem[mem_addr[13:2]];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int mode = 0;
    int req_no, stall_left, stall_total, stab_bad, req_cycles;
    int writes, reads;
    bit in_req = 0;
    bit fire = 0;
    bit fire_we;
    logic [31:0] fire_addr, fire_data;
    logic        snap_we;
    logic [31:0] snap_addr, snap_wd;
    logic [31:0] am [64];
    logic [31:0] bm [64];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Responder: decides the grant half a cycle ahead of the sampling edge.
    always @(negedge clk) begin
        bit g;
        fire = 0;
        g = 0;
        if (!rst) begin
            in_req = 0;
            mem_gnt = 0;
        end else if (mem_req) begin
            req_cycles++;
            if (!in_req) begin
                in_req = 1;
                req_no++;
                snap_we = mem_we;
                snap_addr = mem_addr;
                snap_wd = mem_wdata;
                stall_left = (mode == 1 && req_no % 2 == 0) ? 3 : 0;
            end else if ({mem_we, mem_addr, mem_wdata} !==
                         {snap_we, snap_addr, snap_wd}) begin
                stab_bad++;
            end
            case (mode)
                0: g = 1;
                1: g = (stall_left == 0);
                2: g = ($urandom_range(0, 2) != 0);
                default: g = !mem_we;
            endcase
            if (stall_left > 0) stall_left--;
            mem_gnt = g;
            if (g) begin
                fire = 1;
                fire_we = mem_we;
                fire_addr = mem_addr;
                fire_data = mem_wdata;
                in_req = 0;
            end else begin
                stall_total++;
            end
        end else begin
            in_req = 0;
            mem_gnt = (mode == 0) || (mode == 2 && $urandom_range(0, 1) == 1);
        end
    end

    // Monitor: every completed write is popped against the scoreboard.
    always @(posedge clk) begin
        wr_t e;
        if (rst && fire) begin
            if (fire_we) begin
                mem[fire_addr[13:2]] = fire_data;
                writes++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL c_write: unexpected write addr=0x%0h data=0x%0h",
                             fire_addr, fire_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.addr !== fire_addr || e.data !== fire_data) begin
                        failures++;
                        $display("FAIL c_write: got addr=0x%0h data=0x%0h expected addr=0x%0h data=0x%0h",
                                 fire_addr, fire_data, e.addr, e.data);
                    end
                end
            end else begin
                reads++;
            end
        end
    end

    task automatic clear_counts();
        req_no = 0;
        stall_left = 0;
        stall_total = 0;
        stab_bad = 0;
        req_cycles = 0;
        writes = 0;
        reads = 0;
    endtask

    task automatic load_and_model(input int n, input logic [31:0] ba,
                                  input logic [31:0] bb, input logic [31:0] bc,
                                  input bit push);
        logic [31:0] sum;
        for (int x = 0; x < n * n; x++) begin
            mem[ba[13:2] + 12'(x)] = am[x];
            mem[bb[13:2] + 12'(x)] = bm[x];
        end
        if (push) begin
            for (int i = 0; i < n; i++)
                for (int j = 0; j < n; j++) begin
                    sum = 0;
                    for (int k = 0; k < n; k++)
                        sum += am[i * n + k] * bm[k * n + j];
                    exp_q.push_back('{addr: bc + 32'(4 * (i * n + j)), data: sum});
                end
        end
    endtask

    task automatic run(input int n, input logic [31:0] ba, input logic [31:0] bb,
                       input logic [31:0] bc, input int md, input bit mid);
        int cyc, busy_bad, exp_cyc, tot;
        bit ok_n;
        ok_n = (n >= 1 && n <= 8);
        if (ok_n) load_and_model(n, ba, bb, bc, 1);
        mode = md;
        clear_counts();
        @(posedge clk);
        #1 start = 1; dim = 4'(n); base_a = ba; base_b = bb; base_c = bc;
        @(posedge clk);
        #1 start = 0;
        cyc = 1;
        busy_bad = 0;
        while (!done && cyc < 20000) begin
            if (busy !== 1'b1) busy_bad++;
            if (mid && cyc == 6) begin
                start = 1; base_c = bc + 32'h1000; dim = 4'd1;
            end
            if (mid && cyc == 7) start = 0;
            @(posedge clk);
            #1 cyc++;
        end
        tot = ok_n ? n * n * (3 * n + 1) : 0;
        exp_cyc = tot + 1 + stall_total;
        check("done_seen", 64'(done), 64'd1);
        check("done_cycle", 64'(cyc), 64'(exp_cyc));
        check("busy_at_done", 64'(busy), 64'd0);
        check("busy_during_run", 64'(busy_bad), 64'd0);
        check("err_at_done", 64'(err), 64'(n > 8));
        @(posedge clk);
        #1;
        check("done_single_cycle", 64'(done), 64'd0);
        check("err_held", 64'(err), 64'(n > 8));
        base_c = bc;
        dim = 4'(n);
        check("write_count", 64'(writes), ok_n ? 64'(n * n) : 64'd0);
        check("read_count", 64'(reads), ok_n ? 64'(2 * n * n * n) : 64'd0);
        check("req_cycles", 64'(req_cycles), 64'(reads + writes + stall_total));
        check("req_stable", 64'(stab_bad), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n, found;
        logic [31:0] ba, bb, bc;
        for (int x = 0; x < 4096; x++) mem[x] = '0;
        #3;
        check("reset_outputs",
              64'({busy, done, err, mem_req, mem_we, mem_addr, mem_wdata}), 64'd0);
        #20 rst = 1;

        am[0:3] = '{32'd1, 32'd2, 32'd3, 32'd4};
        bm[0:3] = '{32'd5, 32'd6, 32'd7, 32'd8};
        run(2, 32'h100, 32'h200, 32'h300, 0, 0);
        check("basic_c00", 64'(mem[12'h0C0]), 64'd19);
        check("basic_c01", 64'(mem[12'h0C1]), 64'd22);
        check("basic_c10", 64'(mem[12'h0C2]), 64'd43);
        check("basic_c11", 64'(mem[12'h0C3]), 64'd50);
        check("basic_stalls", 64'(stall_total), 64'd0);

        for (int x = 0; x < 4; x++) mem[12'h0C0 + 12'(x)] = '0;
        run(2, 32'h100, 32'h200, 32'h300, 1, 0);
        check("stall_total", 64'(stall_total), 64'd30);
        check("stall_c11", 64'(mem[12'h0C3]), 64'd50);

        for (int x = 0; x < 9; x++) begin
            am[x] = (x % 4 == 0) ? 32'd1 : 32'd0;
            bm[x] = 32'hFFFF_FFFF;
        end
        run(3, 32'h100, 32'h400, 32'h800, 2, 0);
        for (int x = 0; x < 9; x++)
            check("ident_c", 64'(mem[12'h200 + 12'(x)]), 64'hFFFF_FFFF);

        am[0] = 32'h8000_0000;
        bm[0] = 32'd2;
        mem[12'h300] = 32'h1;
        run(1, 32'h0, 32'h40, 32'hC00, 0, 0);
        check("wrap_c", 64'(mem[12'h300]), 64'd0);

        run(0, 32'h0, 32'h40, 32'h80, 0, 0);
        run(9, 32'h0, 32'h40, 32'h80, 0, 0);

        for (int x = 0; x < 9; x++) begin
            am[x] = $urandom;
            bm[x] = $urandom;
        end
        run(3, 32'h100, 32'h400, 32'h800, 0, 1);

        am[0:3] = '{32'd1, 32'd2, 32'd3, 32'd4};
        bm[0:3] = '{32'd5, 32'd6, 32'd7, 32'd8};
        for (int x = 0; x < 4; x++) mem[12'h0C0 + 12'(x)] = 32'hDEAD_BEEF;
        load_and_model(2, 32'h100, 32'h200, 32'h300, 0);
        mode = 3;
        clear_counts();
        @(posedge clk);
        #1 start = 1; dim = 4'd2; base_a = 32'h100; base_b = 32'h200; base_c = 32'h300;
        @(posedge clk);
        #1 start = 0;
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            if (mem_req && mem_we) found = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("rst_reached_wr", 64'(found), 64'd1);
        #2 rst = 0;
        #1;
        check("rst_async_outputs",
              64'({busy, done, err, mem_req, mem_we, mem_addr, mem_wdata}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_no_write", 64'(writes), 64'd0);
        check("rst_c_untouched", 64'(mem[12'h0C0]), 64'hDEAD_BEEF);
        rst = 1;
        run(2, 32'h100, 32'h200, 32'h300, 0, 0);
        check("post_rst_c00", 64'(mem[12'h0C0]), 64'd19);

        for (int t = 0; t < 6; t++) begin
            n = (t == 0) ? 8 : int'($urandom_range(1, 8));
            for (int x = 0; x < n * n; x++) begin
                am[x] = $urandom;
                bm[x] = $urandom;
            end
            ba = 32'h000 + 32'(4 * $urandom_range(0, 63));
            bb = 32'h400 + 32'(4 * $urandom_range(0, 63));
            bc = 32'h800 + 32'(4 * $urandom_range(0, 63));
            run(n, ba, bb, bc, 2, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matmac_sequencer.md
Name: matmac_sequencer

Overview:
- Multi-cycle controller that computes C = A x B for square N x N matrices of 32-bit integers held in the shared data memory.
- Walks indices i, j and k, reads A[i][k] and B[k][j] through a request/grant port, accumulates their product, then writes C[i][j].
- Sits beside the single-cycle core. The core's data-memory arbiter grants this block the memory port only when the core is not using it.
- Software configures the bases and dim, pulses start, then polls busy/done.

Parameters:
- MAX_N, 8: largest supported matrix dimension.
- AW, 32: address width (byte addresses, word aligned).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle launch pulse; sampled only in IDLE.
- dim  in  4  matrix dimension N.
- base_a  in  AW  byte address of A[0][0], row-major.
- base_b  in  AW  byte address of B[0][0], row-major.
- base_c  in  AW  byte address of C[0][0], row-major.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  high with done when dim > MAX_N; held until the next start.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  AW  access address.
- mem_wdata  out  32  write data.
- mem_gnt  in  1  the access completes in any cycle where mem_req && mem_gnt.
- mem_rdata  in  32  read data; combinational, valid in the granted read cycle.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. busy, done, err, mem_req, mem_we = 0. mem_addr, mem_wdata = 0. i, j, k = 0. Accumulator and operand registers = 0.
- IDLE: on start=1, latch dim and the three bases, clear i/j/k/acc/err.
  - dim==0: go to DONE (no memory traffic).
  - dim>MAX_N: set err=1, go to DONE (no memory traffic).
  - Otherwise go to RD_A.
- RD_A: mem_req=1, mem_we=0, mem_addr = base_a + ((i*N+k)<<2). Hold every request output stable until granted. On grant, capture mem_rdata into op_a and go to RD_B.
- RD_B: mem_addr = base_b + ((k*N+j)<<2). On grant, capture op_b and go to MAC.
- MAC (1 cycle, mem_req=0): acc <= acc + low32(op_a*op_b). Arithmetic is unsigned-agnostic two's complement, wrapping modulo 2^32. No saturation; no overflow flag.
  - If k==N-1: go to WR_C.
  - Else: k++, go to RD_A.
- WR_C: mem_req=1, mem_we=1, mem_addr = base_c + ((i*N+j)<<2), mem_wdata=acc. On grant: clear k and acc, then advance j.
  - If j==N-1: j=0, i++.
  - If i==N-1 && j==N-1: go to DONE.
  - Else: go to RD_A.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- busy=1 in RD_A, RD_B, MAC and WR_C. busy=0 in IDLE and DONE.
- start while busy is ignored. Input changes after launch have no effect, because the values are latched.
- Grant wait: mem_gnt=0 stalls in place with mem_req, mem_we, mem_addr and mem_wdata unchanged. No timeout. mem_req never drops before its grant.
- Latency with mem_gnt tied high: start seen at edge 0, then N^2*(3N+1) busy cycles, then done. Example: N=2 gives done high in cycle 29.
- Address arithmetic: index products fit in 6 bits (MAX_N^2 = 64). Address addition wraps modulo 2^AW; no bounds check.
- Reset mid-operation: immediate return to IDLE; any ungranted write is abandoned. C keeps whatever was already written.
- mem_gnt while mem_req=0 is ignored.

Test Plan:
- Basic 2x2, gnt tied 1: A=[[1,2],[3,4]] at 0x100, B=[[5,6],[7,8]] at 0x200, base_c=0x300, dim=2.
  - Required: C=[[19,22],[43,50]] at 0x300..0x30C.
  - Required: exactly 4 writes and 16 reads.
  - Required: done single-cycle in cycle 29; busy high in cycles 1-28.
- Stall: same data, gnt low for 3 cycles on every 2nd request.
  - Required: identical C.
  - Required: request outputs stable throughout each stall.
  - Required: done delayed by exactly the number of stall cycles.
- Wrap/identity: dim=3 with A=identity, B all 0xFFFFFFFF.
  - Required: C all 0xFFFFFFFF.
  - Wrap check: A=[[0x80000000]], B=[[2]], dim=1 gives C=0x00000000.
- Degenerate: dim=0 gives done in cycle 1, err=0, no mem_req. dim=9 gives done in cycle 1, err=1, no mem_req.
- Start while busy: pulse start again mid-run with different base_c.
  - Required: ignored; results land only at the original base_c.
- Reset mid-op: assert rst during the first WR_C while gnt=0.
  - Required: outputs go to 0 asynchronously and no write occurs.
  - Required: a following start runs to a correct result.
